// File: rtl/cache_pkg.sv
// Shared types, encodings and helpers for the N-way data cache.
package cache_pkg;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, MISS, REPLACE, REFILL,
        UNC_RD, UNC_WAIT, UNC_WR, RESP
    } dcache_state_t;

    localparam logic [2:0] RD_WORD = 3'b010;
    localparam logic [2:0] RD_LINE = 3'b100;
    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    function automatic int way_w(input int nways);
        return (nways > 1) ? $clog2(nways) : 1;
    endfunction

    function automatic logic [31:0] merge_word(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = strb[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/dcache_nway_lfsr8.sv
// 8-bit maximal-length LFSR used to pick replacement victims.
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic fb;

    // taps 8,6,5,4
    assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 8'hA5;
        else     q <= {q[6:0], fb};
    end

endmodule

// File: rtl/dcache_nway.sv
// Blocking N-way set-associative write-back data cache with uncached path.
module dcache_nway
    import cache_pkg::*;
#(
    parameter int NSETS      = 256,
    parameter int NWAYS      = 2,
    parameter int LINE_WORDS = 4,
    parameter int IW         = $clog2(NSETS),
    parameter int OW         = $clog2(LINE_WORDS) + 2,
    parameter int TW         = ADDR_W - IW - OW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid,
    input  logic                     op,
    input  logic                     uncache,
    input  logic [IW-1:0]            index,
    input  logic [TW-1:0]            tag,
    input  logic [OW-1:0]            offset,
    input  logic [3:0]               wstrb,
    input  logic [31:0]              wdata,
    output logic                     addr_ok,
    output logic                     data_ok,
    output logic [31:0]              rdata,
    output logic                     rd_req,
    output logic [2:0]               rd_type,
    output logic [31:0]              rd_addr,
    input  logic                     rd_rdy,
    input  logic                     ret_valid,
    input  logic                     ret_last,
    input  logic [31:0]              ret_data,
    output logic                     wr_req,
    output logic [2:0]               wr_type,
    output logic [31:0]              wr_addr,
    output logic [3:0]               wr_wstrb,
    output logic [32*LINE_WORDS-1:0] wr_data,
    input  logic                     wr_rdy
);

    localparam int WAYW = way_w(NWAYS);
    localparam int CW   = OW - 2;
    localparam int LB   = WORD_W * LINE_WORDS;

    dcache_state_t state_q, state_d;

    logic            req_op, req_unc;
    logic [IW-1:0]   req_idx;
    logic [TW-1:0]   req_tag;
    logic [OW-1:0]   req_off;
    logic [3:0]      req_strb;
    logic [31:0]     req_wdata;
    logic [CW-1:0]   req_word;

    logic [NSETS-1:0][NWAYS-1:0] v_q, d_q;
    logic [TW-1:0]   tag_arr  [NSETS][NWAYS];
    logic [LB-1:0]   data_arr [NSETS][NWAYS];

    logic [WAYW-1:0] victim_q, victim_c, hit_way;
    logic            hit, store_hit, beat, fill_done;
    logic [31:0]     hit_word, beat_w, resp_q;
    logic [CW-1:0]   cnt_q;
    logic [LB-1:0]   buf_q, fill_line;
    logic [7:0]      lfsr_q;

    lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign req_word  = req_off[OW-1:2];
    assign store_hit = (state_q == LOOKUP) && !req_unc && hit && req_op;
    assign beat      = (state_q == REFILL) && ret_valid;
    assign fill_done = beat && ret_last;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NWAYS; w++)
            if (v_q[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAYW'(w);
            end
        hit_word = data_arr[req_idx][hit_way][32*req_word +: 32];
    end

    // lowest invalid way wins, random way otherwise
    always_comb begin
        victim_c = WAYW'(lfsr_q % 8'(NWAYS));
        for (int w = NWAYS - 1; w >= 0; w--)
            if (!v_q[req_idx][w]) victim_c = WAYW'(w);
    end

    always_comb begin
        beat_w = ret_data;
        if (req_op && cnt_q == req_word)
            beat_w = merge_word(ret_data, req_wdata, req_strb);
        fill_line = buf_q;
        fill_line[32*cnt_q +: 32] = beat_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        addr_ok  = 1'b0;
        data_ok  = 1'b0;
        rdata    = '0;
        rd_req   = 1'b0;
        rd_type  = '0;
        rd_addr  = '0;
        wr_req   = 1'b0;
        wr_type  = '0;
        wr_addr  = '0;
        wr_wstrb = '0;
        wr_data  = '0;
        unique case (state_q)
            IDLE: begin
                addr_ok = !rst;
                if (valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (req_unc) begin
                    state_d = req_op ? UNC_WR : UNC_RD;
                end else if (hit) begin
                    data_ok = 1'b1;
                    rdata   = hit_word;
                    state_d = IDLE;
                end else begin
                    state_d = MISS;
                end
            end
            MISS: begin
                if (v_q[req_idx][victim_q] && d_q[req_idx][victim_q]) begin
                    wr_req  = 1'b1;
                    wr_type = RD_LINE;
                    wr_addr = {tag_arr[req_idx][victim_q], req_idx, {OW{1'b0}}};
                    wr_data = data_arr[req_idx][victim_q];
                    if (wr_rdy) state_d = REPLACE;
                end else begin
                    state_d = REPLACE;
                end
            end
            REPLACE: begin
                rd_req  = 1'b1;
                rd_type = RD_LINE;
                rd_addr = {req_tag, req_idx, {OW{1'b0}}};
                if (rd_rdy) state_d = REFILL;
            end
            REFILL: begin
                if (fill_done) state_d = RESP;
            end
            UNC_RD: begin
                rd_req  = 1'b1;
                rd_type = RD_WORD;
                rd_addr = {req_tag, req_idx, req_off};
                if (rd_rdy) state_d = UNC_WAIT;
            end
            UNC_WAIT: begin
                if (ret_valid) state_d = RESP;
            end
            UNC_WR: begin
                wr_req        = 1'b1;
                wr_type       = RD_WORD;
                wr_addr       = {req_tag, req_idx, req_off};
                wr_wstrb      = req_strb;
                wr_data[31:0] = req_wdata;
                if (wr_rdy) state_d = RESP;
            end
            RESP: begin
                data_ok = 1'b1;
                rdata   = resp_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_op    <= 1'b0;
            req_unc   <= 1'b0;
            req_idx   <= '0;
            req_tag   <= '0;
            req_off   <= '0;
            req_strb  <= '0;
            req_wdata <= '0;
            victim_q  <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            resp_q    <= '0;
            v_q       <= '0;
            d_q       <= '0;
        end else begin
            if (state_q == IDLE && valid) begin
                req_op    <= op;
                req_unc   <= uncache;
                req_idx   <= index;
                req_tag   <= tag;
                req_off   <= offset;
                req_strb  <= wstrb;
                req_wdata <= wdata;
            end
            if (state_q == LOOKUP) begin
                cnt_q <= '0;
                if (!req_unc && !hit) victim_q <= victim_c;
            end
            if (beat) begin
                buf_q <= fill_line;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == req_word) resp_q <= beat_w;
            end
            if (state_q == UNC_WAIT && ret_valid) resp_q <= ret_data;
            if (fill_done) begin
                v_q[req_idx][victim_q] <= 1'b1;
                d_q[req_idx][victim_q] <= req_op;
            end
            if (store_hit) d_q[req_idx][hit_way] <= 1'b1;
        end
    end

    // payload arrays carry no reset; validity lives in v_q
    always_ff @(posedge clk) begin
        if (store_hit)
            data_arr[req_idx][hit_way][32*req_word +: 32] <=
                merge_word(hit_word, req_wdata, req_strb);
        if (fill_done) begin
            data_arr[req_idx][victim_q] <= fill_line;
            tag_arr[req_idx][victim_q]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_dcache_nway.sv
// Directed scoreboard bench for dcache_nway (default 256x2x4 config).
module tb_dcache_nway;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid, op, uncache;
    logic [7:0]   index;
    logic [19:0]  tag;
    logic [3:0]   offset;
    logic [3:0]   wstrb;
    logic [31:0]  wdata;
    logic         addr_ok, data_ok;
    logic [31:0]  rdata;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy, ret_valid, ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    int vecs = 0;
    int errs = 0;
    logic [32:0] sb_q[$];

    localparam logic [127:0] L1 = {32'h00A300A3, 32'h00A200A2, 32'h00A100A1, 32'h00A000A0};
    localparam logic [127:0] L2 = {32'h00B300B3, 32'h00B200B2, 32'h00B100B1, 32'h00B000B0};
    localparam logic [127:0] L3 = {32'h00C300C3, 32'h00C200C2, 32'h00C100C1, 32'h00C000C0};
    localparam logic [127:0] L5 = {32'h00D300D3, 32'h00D200D2, 32'h00D100D1, 32'h00D000D0};

    always #5 clk = ~clk;

    dcache_nway dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .op        (op),
        .uncache   (uncache),
        .index     (index),
        .tag       (tag),
        .offset    (offset),
        .wstrb     (wstrb),
        .wdata     (wdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .wr_req    (wr_req),
        .wr_type   (wr_type),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy)
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", nm, got, exp);
        end
    endtask

    task automatic issue(input logic o, input logic u, input logic [19:0] t,
                         input logic [7:0] i, input logic [3:0] off,
                         input logic [3:0] s, input logic [31:0] d,
                         input logic cmp, input logic [31:0] exp);
        @(negedge clk);
        chk("idle_no_data_ok", {127'd0, data_ok}, 128'd0);
        chk("addr_ok", {127'd0, addr_ok}, 128'd1);
        valid = 1'b1; op = o; uncache = u; tag = t; index = i;
        offset = off; wstrb = s; wdata = d;
        sb_q.push_back({cmp, exp});
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_resp(input int max);
        logic [32:0] e;
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < max && !seen; c++) begin
            @(negedge clk);
            if (data_ok) seen = 1'b1;
        end
        chk("data_ok_in_time", {127'd0, seen}, 128'd1);
        if (seen && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e[32]) chk("rdata", {96'd0, rdata}, {96'd0, e[31:0]});
        end
    endtask

    task automatic serve_rd(input logic [2:0] ty, input logic [31:0] ad,
                            input int nb, input logic [127:0] ln, input logic no_wr);
        logic seen, wr_seen;
        seen = 1'b0;
        wr_seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (wr_req) wr_seen = 1'b1;
            if (rd_req) seen = 1'b1;
        end
        chk("rd_req_seen", {127'd0, seen}, 128'd1);
        if (no_wr) chk("no_wr_req", {127'd0, wr_seen}, 128'd0);
        chk("rd_type", {125'd0, rd_type}, {125'd0, ty});
        chk("rd_addr", {96'd0, rd_addr}, {96'd0, ad});
        rd_rdy = 1'b1;
        @(posedge clk); #1;
        rd_rdy = 1'b0;
        for (int b = 0; b < nb; b++) begin
            ret_valid = 1'b1;
            ret_last  = (b == nb - 1);
            ret_data  = ln[32*b +: 32];
            @(posedge clk); #1;
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
    endtask

    initial begin
        logic [31:0] first_addr;
        logic [127:0] evict_ln;
        logic seen, rd_early;
        rst = 1'b1; valid = 1'b0; op = 1'b0; uncache = 1'b0;
        index = '0; tag = '0; offset = '0; wstrb = '0; wdata = '0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
        wr_rdy = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_addr_ok", {127'd0, addr_ok}, 128'd0);
        chk("rst_ctrl", {124'd0, data_ok, rd_req, wr_req, 1'b0}, 128'd0);
        chk("rst_addr", {64'd0, rd_addr, wr_addr}, 128'd0);
        chk("rst_wr_data", wr_data, 128'd0);
        rst = 1'b0;

        // clean read miss
        issue(0, 0, 20'h12345, 8'd3, 4'h4, 4'h0, 0, 1, 32'h00A100A1);
        serve_rd(3'b100, 32'h12345030, 4, L1, 1);
        wait_resp(3);

        // store hit, then load hit on merged word
        issue(1, 0, 20'h12345, 8'd3, 4'h8, 4'b0011, 32'hDEADBEEF, 0, 0);
        wait_resp(1);
        issue(0, 0, 20'h12345, 8'd3, 4'h8, 4'h0, 0, 1, 32'h00A2BEEF);
        wait_resp(1);

        // second way, then dirty it
        issue(0, 0, 20'h0ABCD, 8'd3, 4'h0, 4'h0, 0, 1, 32'h00B000B0);
        serve_rd(3'b100, 32'h0ABCD030, 4, L2, 1);
        wait_resp(3);
        issue(1, 0, 20'h0ABCD, 8'd3, 4'hC, 4'hF, 32'h11223344, 0, 0);
        wait_resp(1);

        // uncached load to a cached address
        issue(0, 1, 20'h12345, 8'd3, 4'h4, 4'h0, 0, 1, 32'hCAFEF00D);
        serve_rd(3'b010, 32'h12345034, 1, {96'd0, 32'hCAFEF00D}, 1);
        wait_resp(3);
        issue(0, 0, 20'h12345, 8'd3, 4'h4, 4'h0, 0, 1, 32'h00A100A1);
        wait_resp(1);

        // dirty eviction under write backpressure
        issue(0, 0, 20'h55555, 8'd3, 4'h0, 4'h0, 0, 1, 32'h00C000C0);
        seen = 1'b0;
        rd_early = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (rd_req) rd_early = 1'b1;
            if (wr_req) seen = 1'b1;
        end
        chk("wr_req_seen", {127'd0, seen}, 128'd1);
        chk("rd_before_wr", {127'd0, rd_early}, 128'd0);
        chk("wr_type", {125'd0, wr_type}, 128'd4);
        first_addr = wr_addr;
        chk("victim_addr", {127'd0, (wr_addr == 32'h12345030) || (wr_addr == 32'h0ABCD030)}, 128'd1);
        evict_ln = (wr_addr == 32'h12345030)
                 ? {L1[127:96], 32'h00A2BEEF, L1[63:0]}
                 : {32'h11223344, L2[95:0]};
        chk("victim_data", wr_data, evict_ln);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_wr_req", {127'd0, wr_req}, 128'd1);
            chk("bp_wr_addr", {96'd0, wr_addr}, {96'd0, first_addr});
            chk("bp_rd_req", {127'd0, rd_req}, 128'd0);
        end
        wr_rdy = 1'b1;
        @(posedge clk); #1;
        wr_rdy = 1'b0;
        serve_rd(3'b100, 32'h55555030, 4, L3, 1);
        wait_resp(3);
        if (first_addr == 32'h12345030)
            issue(0, 0, 20'h0ABCD, 8'd3, 4'hC, 4'h0, 0, 1, 32'h11223344);
        else
            issue(0, 0, 20'h12345, 8'd3, 4'h8, 4'h0, 0, 1, 32'h00A2BEEF);
        wait_resp(1);
        issue(0, 0, 20'h55555, 8'd3, 4'h4, 4'h0, 0, 1, 32'h00C100C1);
        wait_resp(1);

        // uncached store
        issue(1, 1, 20'h0F0F0, 8'd7, 4'h4, 4'b0101, 32'h12345678, 0, 0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (wr_req) seen = 1'b1;
        end
        chk("unc_wr_req", {127'd0, seen}, 128'd1);
        chk("unc_wr_type", {125'd0, wr_type}, 128'd2);
        chk("unc_wr_addr", {96'd0, wr_addr}, {96'd0, 32'h0F0F0074});
        chk("unc_wr_strb", {124'd0, wr_wstrb}, 128'd5);
        chk("unc_wr_data", {96'd0, wr_data[31:0]}, {96'd0, 32'h12345678});
        wr_rdy = 1'b1;
        @(posedge clk); #1;
        wr_rdy = 1'b0;
        wait_resp(2);

        // reset in the middle of a refill
        issue(0, 0, 20'h00777, 8'd5, 4'h0, 4'h0, 0, 1, 32'h00D000D0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (rd_req) seen = 1'b1;
        end
        chk("rst_test_rd_req", {127'd0, seen}, 128'd1);
        rd_rdy = 1'b1;
        @(posedge clk); #1;
        rd_rdy = 1'b0;
        for (int b = 0; b < 2; b++) begin
            ret_valid = 1'b1;
            ret_data  = L5[32*b +: 32];
            @(posedge clk); #1;
        end
        ret_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", {124'd0, addr_ok, data_ok, rd_req, wr_req}, 128'd0);
        chk("midrst_addr", {64'd0, rd_addr, wr_addr}, 128'd0);
        chk("midrst_rdata", {96'd0, rdata}, 128'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_data_ok", {127'd0, data_ok}, 128'd0);
        end
        rst = 1'b0;
        sb_q.delete();
        issue(0, 0, 20'h00777, 8'd5, 4'h4, 4'h0, 0, 1, 32'h00D100D1);
        serve_rd(3'b100, 32'h00777050, 4, L5, 1);
        wait_resp(3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
